keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Sequencing controller for the 4x4 keypad front end of the Booth multiplier.
- Drives the one-hot column strobe consumed by row_scanner and synchronizes the raw keypad rows.
- Debounces key press and release, then registers the decoded key from row_scanner.
- Emits exactly one key_valid pulse per physical press to the operand-entry logic.

Parameters:
SCAN_DIV, 4, slow_clk cycles each column stays active while idle (>=1)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required for press and for release (>=1)

Ports:
slow_clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low
row_in  input  4  raw keypad rows, asynchronous to slow_clk
key_value  input  4  decoded key from row_scanner (combinational from col_shift_reg, row_sync)
is_sign_key  input  3  sign/operator code from row_scanner
col_shift_reg  output  4  one-hot column drive to keypad and row_scanner
row_sync  output  4  2-flop synchronized rows, fed to row_scanner row_in
key_valid  output  1  one-cycle pulse, new key registered
key_code  output  4  registered key_value, held until next key_valid
key_sign  output  3  registered is_sign_key, held until next key_valid
busy  output  1  high whenever state != SCAN

Behaviour:
- Reset values (rst low, async): col_shift_reg=4'b1000, both sync flops=0, row_sync=0, state=SCAN, scan_cnt=0, deb_cnt=0, row_snap=0, key_valid=0, key_code=0, key_sign=0, busy=0.
- Synchronizer: row_in -> flop1 -> flop2 = row_sync. All FSM decisions use row_sync only.
- Column rotation order: 1000 -> 0100 -> 0010 -> 0001 -> 1000. col_shift_reg is always exactly one-hot.
- SCAN:
  - If row_sync == 0: scan_cnt increments.
  - At scan_cnt == SCAN_DIV-1: rotate column, scan_cnt=0.
  - If row_sync != 0: go to DEBOUNCE, row_snap=row_sync, deb_cnt=0, column held, scan_cnt=0.
- DEBOUNCE (column held):
  - If row_sync != row_snap: return to SCAN with no pulse. Column is unchanged and scanning resumes from the held column.
  - Else deb_cnt increments. On the edge where deb_cnt == DEBOUNCE_CYCLES-1 with a match:
    - If row_snap is one-hot: key_code<=key_value, key_sign<=is_sign_key, key_valid<=1.
    - If more than one row bit is set (multi-key): no capture, no pulse.
    - In both cases go to WAIT_RELEASE with deb_cnt=0.
- WAIT_RELEASE (column held):
  - key_valid is forced 0 (pulse width exactly 1 cycle).
  - Each cycle with row_sync == 0 increments deb_cnt. Any nonzero row_sync clears deb_cnt.
  - On the edge where deb_cnt == DEBOUNCE_CYCLES-1 and row_sync == 0: go to SCAN and advance the column one step.
- Latency: row_in stable before edge 0 -> row_sync valid after edge 1 -> DEBOUNCE after edge 2 -> key_valid high in the cycle after edge 2+DEBOUNCE_CYCLES (edge 10 for the default).
- Holding a key indefinitely produces exactly one pulse.
- A new press is accepted only after a full release debounce.
- Counters are sized by clog2 of their parameter and never wrap past the terminal value.
- Async reset asserted in any state returns immediately to the reset values. An in-flight debounce is discarded and no pulse is emitted.
- key_code and key_sign change only on a key_valid edge or on reset.

Test Plan:
- Reset, no keys, SCAN_DIV=4: col_shift_reg sequence 1000,0100,0010,0001,1000 with each value held 4 cycles; busy=0; key_valid never high.
- Keypad model presses "5" (row 0100 when col 0010) and holds 40 cycles: exactly one key_valid pulse, 10 edges after DEBOUNCE entry+sync, key_code=4'b0101, key_sign=3'b000; column stays 0010 until release debounce; then 0001 next.
- Press "A" (col 1000, row 1000): key_code=4'b1010, key_sign=3'b001. Press "*" (col 0001, row 0001): key_code=0, key_sign=3'b100.
- Bounce: row toggles 0100/0000 every 3 cycles for 30 cycles, then steady: no pulse during bounce; single pulse after 8 stable synchronized cycles.
- Two rows (1000|0010) pressed in one column: no key_valid; controller waits for release, then resumes scanning at the next column.
- rst pulsed low mid-DEBOUNCE (deb_cnt=5): all outputs return to reset values immediately; no key_valid; scanning restarts at 1000.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scan, row synchronisation, press/release debounce and key capture
// for a 4x4 keypad.
//   slow_clk      - clock, rising edge
//   rst           - asynchronous reset, active low
//   row_in        - raw keypad rows, asynchronous to slow_clk
//   key_value     - decoded key from row_scanner (driven from col_shift_reg and row_sync)
//   is_sign_key   - sign/operator code from row_scanner
//   col_shift_reg - one-hot column drive, rotates 1000 -> 0100 -> 0010 -> 0001 while idle
//   row_sync      - rows after the two-flop synchroniser
//   key_valid     - one-cycle pulse when a new key is registered
//   key_code      - key_value captured on the key_valid edge
//   key_sign      - is_sign_key captured on the key_valid edge
//   busy          - high whenever the controller is not scanning
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    input  logic [3:0] key_value,
    input  logic [2:0] is_sign_key,
    output logic [3:0] col_shift_reg,
    output logic [3:0] row_sync,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [2:0] key_sign,
    output logic       busy
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_q, col_d, col_next;
    logic [3:0]    sync1_q, row_sync_q;
    logic [3:0]    row_snap_q, row_snap_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [2:0]    key_sign_q, key_sign_d;
    logic          busy_q, busy_d;
    logic          snap_one_hot;

    assign col_next      = {col_q[0], col_q[3:1]};
    // row_snap is never zero here, so clearing the lowest set bit leaves zero only for one-hot
    assign snap_one_hot  = (row_snap_q & (row_snap_q - 4'd1)) == 4'd0;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        row_snap_d  = row_snap_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_sign_d  = key_sign_q;
        unique case (state_q)
            SCAN: begin
                if (row_sync_q != 4'd0) begin
                    state_d    = DEBOUNCE;
                    row_snap_d = row_sync_q;
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                end else if (scan_cnt_q == SCAN_LAST) begin
                    col_d      = col_next;
                    scan_cnt_d = '0;
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (row_sync_q != row_snap_q) begin
                    state_d   = SCAN;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = WAIT_RELEASE;
                    deb_cnt_d = '0;
                    if (snap_one_hot) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_value;
                        key_sign_d  = is_sign_key;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (row_sync_q != 4'd0) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = SCAN;
                    col_d     = col_next;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
        busy_d = state_d != SCAN;
    end

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            col_q       <= 4'b1000;
            sync1_q     <= 4'd0;
            row_sync_q  <= 4'd0;
            row_snap_q  <= 4'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_sign_q  <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            sync1_q     <= row_in;
            row_sync_q  <= sync1_q;
            row_snap_q  <= row_snap_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_sign_q  <= key_sign_d;
            busy_q      <= busy_d;
        end
    end

    assign col_shift_reg = col_q;
    assign row_sync      = row_sync_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign key_sign      = key_sign_q;
    assign busy          = busy_q;
endmodule
